ahb_decoder_dp: RTL and testbench

//  Parametrised AHB address decoder for one master-side layer; successor of the simple combinational decoder.

---
 rtl/ahb_decoder_dp.sv | 137 +++++++++++++
 tb/tb_ahb_decoder_dp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_dp.sv
// ahb_decoder_dp: AHB address decoder with a registered data-phase select, a built-in
// two-cycle ERROR default slave and a saturating decode-error counter. Define AHB_DEC_REMAP_EN for boot remap.

module ahb_dec_region #(
   parameter int            SW       = 22,
   parameter logic [SW-1:0] LOW      = '0,
   parameter logic [SW-1:0] HIGH     = '0,
   parameter logic [SW-1:0] ALT_LOW  = '0,
   parameter logic [SW-1:0] ALT_HIGH = '0
) (
   input  logic [SW-1:0] slice,
   input  logic          use_alt,
   output logic          hit
);
   logic [SW-1:0] lo, hi;

   assign lo  = use_alt ? ALT_LOW  : LOW;
   assign hi  = use_alt ? ALT_HIGH : HIGH;
   assign hit = (slice >= lo) && (slice <= hi);
endmodule

module ahb_decoder_dp #(
   parameter int SLV_NUM        = 4,
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int REGION_LSB     = 10,
   parameter logic [SLV_NUM*(AHB_ADDR_WIDTH-REGION_LSB)-1:0] SLV_LOW  = '0,
   parameter logic [SLV_NUM*(AHB_ADDR_WIDTH-REGION_LSB)-1:0] SLV_HIGH = '0,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]                htrans,
   input  logic                      hready,
`ifdef AHB_DEC_REMAP_EN
   input  logic                      hremap,
`endif
   input  logic                      err_cnt_clr,
   output logic [SLV_NUM-1:0]        hsel,
   output logic                      default_slv_sel,
   output logic [SLV_NUM:0]          hsel_dp,
   output logic                      def_hready_out,
   output logic                      def_hresp,
   output logic [ERR_CNT_W-1:0]      err_cnt
);
   localparam int SW = AHB_ADDR_WIDTH - REGION_LSB;

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

   ds_state_t        state;
   logic [SW-1:0]    slice;
   logic [SLV_NUM-1:0] hit;
   logic             remap_q;
   logic             err_start;
   logic             err_inc;

   assign slice = haddr[AHB_ADDR_WIDTH-1:REGION_LSB];

`ifdef AHB_DEC_REMAP_EN
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) remap_q <= 1'b0;
      else           remap_q <= hremap;
   end
`else
   assign remap_q = 1'b0;
`endif

   // Slaves 0 and 1 carry each other's window as the alternate (remap) map.
   for (genvar i = 0; i < SLV_NUM; i++) begin : g_slv
      localparam int ALT = (SLV_NUM >= 2 && i < 2) ? (i ^ 1) : i;
      ahb_dec_region #(
         .SW      (SW),
         .LOW     (SLV_LOW [i*SW +: SW]),
         .HIGH    (SLV_HIGH[i*SW +: SW]),
         .ALT_LOW (SLV_LOW [ALT*SW +: SW]),
         .ALT_HIGH(SLV_HIGH[ALT*SW +: SW])
      ) u_rgn (
         .slice  (slice),
         .use_alt(remap_q),
         .hit    (hit[i])
      );
   end

   // Scan from the top down so the lowest-index hit is the one left standing.
   always_comb begin
      hsel = '0;
      for (int i = SLV_NUM-1; i >= 0; i--) begin
         if (hit[i]) begin
            hsel    = '0;
            hsel[i] = 1'b1;
         end
      end
   end

   assign default_slv_sel = ~|hit;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)    hsel_dp <= '0;
      else if (hready)  hsel_dp <= (htrans == 2'b00) ? '0 : {default_slv_sel, hsel};
   end

   assign err_start = hready & default_slv_sel & htrans[1];
   assign err_inc   = err_start & (state != DS_ERR1);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state          <= DS_IDLE;
         def_hready_out <= 1'b1;
         def_hresp      <= 1'b0;
      end else begin
         case (state)
            DS_ERR1: begin
               state          <= DS_ERR2;
               def_hready_out <= 1'b1;
               def_hresp      <= 1'b1;
            end
            default: begin
               if (err_start) begin
                  state          <= DS_ERR1;
                  def_hready_out <= 1'b0;
                  def_hresp      <= 1'b1;
               end else begin
                  state          <= DS_IDLE;
                  def_hready_out <= 1'b1;
                  def_hresp      <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)                 err_cnt <= '0;
      else if (err_cnt_clr)          err_cnt <= '0;
      else if (err_inc && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
   end
endmodule

// File: tb/tb_ahb_decoder_dp.sv
// Bench for ahb_decoder_dp: two instances (plain map and overlapping map with a 2-bit counter)
// share stimulus and are checked every cycle against a behavioural model plus literal expectations.

module tb_ahb_decoder_dp;
   logic        hclk = 1'b0;
   logic        hreset_n = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hready = 1'b1;
   logic        err_cnt_clr = 1'b0;
   logic        hremap = 1'b0;

   logic [3:0] hsel_a, hsel_b;
   logic       dss_a, dss_b;
   logic [4:0] dp_a, dp_b;
   logic       rdy_a, rdy_b, rsp_a, rsp_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int checks = 0;
   int failures = 0;

   // Slice-unit maps: [instance][slave]
   int lo_t[2][4] = '{'{32'h000, 32'h100, 32'h400, 32'h200000},
                      '{32'h000, 32'h100, 32'h800, 32'h3FFFF0}};
   int hi_t[2][4] = '{'{32'h0FF, 32'h1FF, 32'h7FF, 32'h20FFFF},
                      '{32'h1FF, 32'h1FF, 32'h8FF, 32'h3FFFFF}};
   int cmax[2] = '{255, 3};

   int m_dp[2], m_ph[2], m_cnt[2];
   bit m_rm;

   localparam logic [31:0] UNMAP = 32'hFFFF_0000;

   always #5 hclk = ~hclk;

   ahb_decoder_dp #(
      .SLV_NUM(4), .AHB_ADDR_WIDTH(32), .REGION_LSB(10),
      .SLV_LOW ({22'h200000, 22'h000400, 22'h000100, 22'h000000}),
      .SLV_HIGH({22'h20FFFF, 22'h0007FF, 22'h0001FF, 22'h0000FF}),
      .ERR_CNT_W(8)
   ) u_dut_a (
      .hclk(hclk), .hreset_n(hreset_n), .haddr(haddr), .htrans(htrans), .hready(hready),
`ifdef AHB_DEC_REMAP_EN
      .hremap(hremap),
`endif
      .err_cnt_clr(err_cnt_clr), .hsel(hsel_a), .default_slv_sel(dss_a), .hsel_dp(dp_a),
      .def_hready_out(rdy_a), .def_hresp(rsp_a), .err_cnt(cnt_a)
   );

   ahb_decoder_dp #(
      .SLV_NUM(4), .AHB_ADDR_WIDTH(32), .REGION_LSB(10),
      .SLV_LOW ({22'h3FFFF0, 22'h000800, 22'h000100, 22'h000000}),
      .SLV_HIGH({22'h3FFFFF, 22'h0008FF, 22'h0001FF, 22'h0001FF}),
      .ERR_CNT_W(2)
   ) u_dut_b (
      .hclk(hclk), .hreset_n(hreset_n), .haddr(haddr), .htrans(htrans), .hready(hready),
`ifdef AHB_DEC_REMAP_EN
      .hremap(hremap),
`endif
      .err_cnt_clr(err_cnt_clr), .hsel(hsel_b), .default_slv_sel(dss_b), .hsel_dp(dp_b),
      .def_hready_out(rdy_b), .def_hresp(rsp_b), .err_cnt(cnt_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // First slave (lowest index) whose window contains the address slice, or -1.
   function automatic int dec(input int k, input logic [31:0] a, input bit rm);
      int s, j2, r;
      r = -1;
      s = int'(a[31:10]);
      for (int j = 3; j >= 0; j--) begin
         j2 = (rm && j < 2) ? (j ^ 1) : j;
         if (s >= lo_t[k][j2] && s <= hi_t[k][j2]) r = j;
      end
      return r;
   endfunction

   // m_ph = data-phase cycle of an ERROR in progress (0 none, 1 first, 2 second).
   task automatic model_step(input int k);
      int idx;
      if (!hreset_n) begin
         m_dp[k] = 0; m_ph[k] = 0; m_cnt[k] = 0;
      end else begin
         idx = dec(k, haddr, m_rm);
         if (m_ph[k] == 1) m_ph[k] = 2;
         else if (hready && idx < 0 && htrans >= 2) begin
            m_ph[k] = 1;
            if (m_cnt[k] < cmax[k]) m_cnt[k]++;
         end else m_ph[k] = 0;
         if (err_cnt_clr) m_cnt[k] = 0;
         if (hready) m_dp[k] = (htrans == 2'b00) ? 0 : (idx < 0 ? 16 : (1 << idx));
      end
   endtask

   task automatic cmp_inst(input int k, input int hs, input int ds, input int dp,
                           input int rdy, input int rsp, input int cnt);
      int idx;
      idx = dec(k, haddr, m_rm);
      chk($sformatf("hsel[%0d]", k), hs, idx < 0 ? 0 : (1 << idx));
      chk($sformatf("default_slv_sel[%0d]", k), ds, idx < 0 ? 1 : 0);
      chk($sformatf("hsel_dp[%0d]", k), dp, m_dp[k]);
      chk($sformatf("def_hready_out[%0d]", k), rdy, m_ph[k] != 1 ? 1 : 0);
      chk($sformatf("def_hresp[%0d]", k), rsp, m_ph[k] != 0 ? 1 : 0);
      chk($sformatf("err_cnt[%0d]", k), cnt, m_cnt[k]);
   endtask

   // Compare process: advance the model on each edge, then check both instances.
   initial begin
      forever begin
         @(posedge hclk);
         model_step(0);
         model_step(1);
         m_rm = hreset_n ? bit'(hremap) : 1'b0;
`ifndef AHB_DEC_REMAP_EN
         m_rm = 1'b0;
`endif
         #1;
         cmp_inst(0, int'(hsel_a), int'(dss_a), int'(dp_a), int'(rdy_a), int'(rsp_a), int'(cnt_a));
         cmp_inst(1, int'(hsel_b), int'(dss_b), int'(dp_b), int'(rdy_b), int'(rsp_b), int'(cnt_b));
      end
   end

   task automatic drv(input logic [31:0] a, input logic [1:0] t, input logic r, input logic c);
      @(negedge hclk);
      haddr = a; htrans = t; hready = r; err_cnt_clr = c;
   endtask

   task automatic after_edge;
      @(posedge hclk);
      #2;
   endtask

   int bnd[16] = '{32'h000, 32'h0FF, 32'h100, 32'h1FF, 32'h200, 32'h3FF, 32'h400, 32'h7FF,
                   32'h800, 32'h8FF, 32'h200000, 32'h20FFFF, 32'h210000, 32'h3FFFEF,
                   32'h3FFFF0, 32'h3FFFFF};

   initial begin
      logic [31:0] a;
      // Reset state
      repeat (2) after_edge;
      chk("rst_dp", int'(dp_a), 0);
      chk("rst_rdy", int'(rdy_a), 1);
      chk("rst_rsp", int'(rsp_a), 0);
      chk("rst_cnt", int'(cnt_a), 0);
      @(negedge hclk) hreset_n = 1'b1;

      // Mapped access to S1
      drv(32'h0004_0010, 2'd2, 1'b1, 1'b0);
      #1 chk("t1_hsel", int'(hsel_a), 4'b0010);
      after_edge;
      chk("t1_dp", int'(dp_a), 5'b00010);
      chk("t1_rdy", int'(rdy_a), 1);

      // Single unmapped access: two-cycle ERROR
      drv(UNMAP, 2'd2, 1'b1, 1'b0);
      #1 chk("t2_dss", int'(dss_a), 1);
      after_edge;
      chk("t2_e1_rdy", int'(rdy_a), 0);
      chk("t2_e1_rsp", int'(rsp_a), 1);
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      after_edge;
      chk("t2_e2_rdy", int'(rdy_a), 1);
      chk("t2_e2_rsp", int'(rsp_a), 1);
      chk("t2_cnt", int'(cnt_a), 1);
      after_edge;
      chk("t2_idle_rdy", int'(rdy_a), 1);
      chk("t2_idle_rsp", int'(rsp_a), 0);

      // Clear, then back-to-back unmapped accesses
      drv(32'h0, 2'd0, 1'b1, 1'b1);
      after_edge;
      chk("clr_cnt", int'(cnt_a), 0);
      drv(UNMAP, 2'd2, 1'b1, 1'b0);
      after_edge;
      chk("b2b_e1a", {rdy_a, rsp_a}, 2'b01);
      drv(UNMAP, 2'd2, 1'b0, 1'b0);
      after_edge;
      chk("b2b_e2a", {rdy_a, rsp_a}, 2'b11);
      drv(UNMAP, 2'd2, 1'b1, 1'b0);
      after_edge;
      chk("b2b_e1b", {rdy_a, rsp_a}, 2'b01);
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      after_edge;
      chk("b2b_e2b", {rdy_a, rsp_a}, 2'b11);
      chk("b2b_cnt", int'(cnt_a), 2);
      after_edge;
      chk("b2b_idle", {rdy_a, rsp_a}, 2'b10);

      // Five more errors: 8-bit counter reaches 7, 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         drv(UNMAP, 2'd2, 1'b1, 1'b0);
         repeat (3) drv(32'h0, 2'd0, 1'b1, 1'b0);
      end
      after_edge;
      chk("sat_cnt_a", int'(cnt_a), 7);
      chk("sat_cnt_b", int'(cnt_b), 3);

      // Clear wins over a same-cycle increment
      drv(UNMAP, 2'd2, 1'b1, 1'b1);
      after_edge;
      chk("clrinc_cnt_a", int'(cnt_a), 0);
      chk("clrinc_cnt_b", int'(cnt_b), 0);
      chk("clrinc_rdy", int'(rdy_a), 0);
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      drv(32'h0, 2'd0, 1'b1, 1'b0);

      // Overlap: slice 0x150 falls in S0 and S1 of instance b; S0 wins. Then hready low holds.
      drv(32'h0005_4000, 2'd2, 1'b1, 1'b0);
      #1 chk("ovl_hsel", int'(hsel_b), 4'b0001);
      after_edge;
      chk("ovl_dp", int'(dp_b), 5'b00001);
      for (int i = 0; i < 3; i++) begin
         drv(UNMAP, 2'd2, 1'b0, 1'b0);
         after_edge;
         chk("hold_dp", int'(dp_b), 5'b00001);
         chk("hold_rsp", int'(rsp_b), 0);
      end

      // Reset during the first ERROR cycle
      drv(UNMAP, 2'd2, 1'b1, 1'b0);
      after_edge;
      chk("rsterr_pre", int'(rdy_a), 0);
      #1 hreset_n = 1'b0;
      #1;
      chk("rsterr_rdy", int'(rdy_a), 1);
      chk("rsterr_rsp", int'(rsp_a), 0);
      chk("rsterr_dp", int'(dp_a), 0);
      chk("rsterr_cnt", int'(cnt_a), 0);
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      after_edge;
      @(negedge hclk) hreset_n = 1'b1;

`ifdef AHB_DEC_REMAP_EN
      // Boot remap: slice 0x010 goes to S1 once hremap is registered
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      hremap = 1'b1;
      after_edge;
      drv(32'h0000_4000, 2'd2, 1'b1, 1'b0);
      #1 chk("remap_hsel", int'(hsel_a), 4'b0010);
      after_edge;
      chk("remap_dp", int'(dp_a), 5'b00010);
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      hremap = 1'b0;
      after_edge;
`endif

      // Randomized traffic, boundary-biased addresses
      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(0, 2))
            0: a = $urandom;
            1: a = (32'(bnd[$urandom_range(0, 15)]) << 10) | 32'($urandom_range(0, 1023));
            default: a = UNMAP | 32'($urandom_range(0, 32'hFFFF));
         endcase
         drv(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
`ifdef AHB_DEC_REMAP_EN
         if ($urandom_range(0, 15) == 0) hremap = ~hremap;
`endif
      end
      drv(32'h0, 2'd0, 1'b1, 1'b0);
      repeat (3) after_edge;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
